dlatch_write_arbiter: RTL

Sequences write access to a shared bank of transparent D latches (DATA_W bits, one common enable) among four requesters. It arbitrates pending requests and drives the selected requester's data onto the latch D inputs. It then frames a glitch-free enable window: data stable before the enable opens and held after it closes, so latch setup and hold are met by construction. It returns a one-cycle acknowledge to the winner. The block sits between requester logic and the latch bank.

---
 rtl/dlatch_write_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/dlatch_write_arbiter.sv
// dlatch_write_arbiter
//   Arbitrates four write requesters onto one bank of transparent D latches
//   that share a common enable. The winner's data is captured once, then a
//   SETUP / OPEN / CLOSE framing keeps latch_d stable for one cycle before
//   the enable rises and for one cycle after it falls. A one-cycle ack
//   follows. Every output is a flop, so latch_en cannot glitch.
//
// Build option:
//   DLATCH_ARB_RR_EN  defined   -> round-robin arbitration. A rotating
//                                  pointer sets where the search starts.
//                     undefined -> fixed priority. The lowest index wins.
//
// Ports:
//   input_clock1_clk_1        clock, rising edge
//   input_push_button2_rst_2  asynchronous reset, active high
//   req      [3:0]            level request per requester
//   wdata    [4*DATA_W-1:0]   requester i data at [i*DATA_W +: DATA_W]
//   latch_d  [DATA_W-1:0]     latch bank D inputs
//   latch_en                  latch bank enable (transparent when 1)
//   grant    [3:0]            one-hot owner of the current write, 0 when idle
//   ack      [3:0]            one-hot single-cycle pulse when the write closes
//   busy                      high in every state except IDLE
module dlatch_write_arbiter #(
  parameter int DATA_W      = 4,
  parameter int OPEN_CYCLES = 2   // 1..15
) (
  input  logic                  input_clock1_clk_1,
  input  logic                  input_push_button2_rst_2,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]     latch_d,
  output logic                  latch_en,
  output logic [3:0]            grant,
  output logic [3:0]            ack,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, CLOSE, ACK} state_t;

  state_t              state, nxt;
  logic [3:0]          cnt;
  logic [1:0]          win;
  logic                any_req;
  logic [DATA_W-1:0]   lane_d [4];

  // Split the flat data bus into one slice per requester.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign lane_d[g] = wdata[g*DATA_W +: DATA_W];
  end

  assign any_req = |req;

`ifdef DLATCH_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] idx;

  // Walk from the highest offset down to the lowest. The lowest offset from
  // ptr is written last, so it wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) win = idx;
    end
  end

  // Only an accepted grant moves the pointer. The pointer wraps naturally in
  // two bits.
  always_ff @(posedge input_clock1_clk_1 or posedge input_push_button2_rst_2) begin
    if (input_push_button2_rst_2)       ptr <= '0;
    else if (state == IDLE && any_req)  ptr <= win + 2'd1;
  end
`else
  always_comb begin
    win = '0;
    for (int i = 3; i >= 0; i--)
      if (req[i]) win = 2'(i);
  end
`endif

  // Next-state logic. OPEN exits when the down-counter reaches zero.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_req) nxt = SETUP;
      SETUP:   nxt = OPEN;
      OPEN:    if (cnt == 4'd0) nxt = CLOSE;
      CLOSE:   nxt = ACK;
      ACK:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register and the OPEN-length counter. The counter loads during
  // SETUP, so OPEN lasts exactly OPEN_CYCLES cycles.
  always_ff @(posedge input_clock1_clk_1 or posedge input_push_button2_rst_2) begin
    if (input_push_button2_rst_2) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == SETUP)                cnt <= 4'(OPEN_CYCLES - 1);
      else if (state == OPEN && cnt != 0) cnt <= cnt - 4'd1;
    end
  end

  // Each output flop is decoded from the next state, so it lines up with the
  // state the FSM is entering. latch_d loads only on the arbitration edge.
  always_ff @(posedge input_clock1_clk_1 or posedge input_push_button2_rst_2) begin
    if (input_push_button2_rst_2) begin
      latch_d  <= '0;
      latch_en <= 1'b0;
      grant    <= '0;
      ack      <= '0;
      busy     <= 1'b0;
    end else begin
      latch_en <= (nxt == OPEN);
      busy     <= (nxt != IDLE);
      ack      <= (nxt == ACK) ? grant : 4'd0;
      if (state == IDLE && any_req) begin
        grant   <= 4'd1 << win;
        latch_d <= lane_d[win];
      end else if (nxt == IDLE) begin
        grant   <= '0;
      end
    end
  end

endmodule
